// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus request/response path.
//   target_e      : which slave a latched request is routed to
//   state_e       : router transaction state
//   DATA_W/ADDR_W : default bus widths (ADDR_W counts 32-bit words)
//   decode_target : folds the decoder selects into a target, RAM first
package bus_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_IO
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // RAM has priority when the decoder flags both regions.
    function automatic target_e decode_target(input logic ram_sel, input logic io_sel);
        target_e tgt;
        tgt = TGT_NONE;
        if (ram_sel) begin
            tgt = TGT_RAM;
        end else if (io_sel) begin
            tgt = TGT_IO;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for an outstanding bus transaction.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at zero (has priority over enable)
//   enable     : advance the count by one this cycle
//   expired    : count has reached LIMIT-1
// The count stops at LIMIT-1, so it never wraps back into a
// "not yet expired" value while the owner keeps enable high.
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/bus_response_router.sv
// CPU data-bus request/response router.
// Accepts one CPU request at a time, routes it to RAM or IO using the
// external address decoder's selects, issues a one-cycle strobe to that
// target, waits for its acknowledge (or a timeout) and returns a one-cycle
// response carrying read data or an error flag.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_*                 : CPU request channel (req_ready_o high in IDLE)
//   ram_select_i/io_select_i : decoder outputs for the presented address
//   ram_req_o/io_req_o    : one-cycle strobes to the targets
//   tgt_*                 : request fields latched at acceptance
//   ram_ack_i/io_ack_i, ram_rdata_i/io_rdata_i : target completion + data
//   rsp_valid_o/rsp_rdata_o/rsp_err_o : response back to the CPU
module bus_response_router
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [3:0]        req_be_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              ram_select_i,
    input  logic              io_select_i,
    output logic              ram_req_o,
    output logic              io_req_o,
    output logic [ADDR_W-1:0] tgt_addr_o,
    output logic              tgt_we_o,
    output logic [3:0]        tgt_be_o,
    output logic [DATA_W-1:0] tgt_wdata_o,
    input  logic              ram_ack_i,
    input  logic              io_ack_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic [DATA_W-1:0] io_rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    state_e            state_reg, state_next;
    target_e           tgt_sel_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              accept;
    logic              finish;
    logic              finish_err;
    logic [DATA_W-1:0] finish_rdata;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_expired;
    logic              ack_hit;
    logic [DATA_W-1:0] ack_rdata;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // Only the latched target's ack counts; the other target is ignored.
    assign ack_hit   = ((tgt_sel_reg == TGT_RAM) && ram_ack_i) ||
                       ((tgt_sel_reg == TGT_IO)  && io_ack_i);
    assign ack_rdata = (tgt_sel_reg == TGT_RAM) ? ram_rdata_i : io_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_rdata = '0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        ram_req_o    = 1'b0;
        io_req_o     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (decode_target(ram_select_i, io_select_i) == TGT_NONE) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                ram_req_o = (tgt_sel_reg == TGT_RAM);
                io_req_o  = (tgt_sel_reg == TGT_IO);
                cnt_clear = 1'b1;
                // An ack alongside the strobe is legal and completes at once.
                if (ack_hit) begin
                    finish       = 1'b1;
                    finish_rdata = tgt_we_o ? '0 : ack_rdata;
                    state_next   = ST_RESP;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_enable = 1'b1;
                if (ack_hit) begin
                    finish       = 1'b1;
                    finish_rdata = tgt_we_o ? '0 : ack_rdata;
                    state_next   = ST_RESP;
                end else if (cnt_expired) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_sel_reg   <= TGT_NONE;
            tgt_addr_o    <= '0;
            tgt_we_o      <= 1'b0;
            tgt_be_o      <= '0;
            tgt_wdata_o   <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                tgt_sel_reg <= decode_target(ram_select_i, io_select_i);
                tgt_addr_o  <= req_addr_i;
                tgt_we_o    <= req_we_i;
                tgt_be_o    <= req_be_i;
                tgt_wdata_o <= req_wdata_i;
            end
            if (finish) begin
                rsp_rdata_reg <= finish_rdata;
                rsp_err_reg   <= finish_err;
            end
        end
    end

    assign req_ready_o = (state_reg == ST_IDLE);
    assign rsp_valid_o = (state_reg == ST_RESP);
    // Response fields are only driven while the pulse is up.
    assign rsp_rdata_o = rsp_valid_o ? rsp_rdata_reg : '0;
    assign rsp_err_o   = rsp_valid_o & rsp_err_reg;

endmodule

// File: tb/tb_bus_response_router.sv
module tb_bus_response_router;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [29:0]   req_addr_i;
    logic          req_we_i;
    logic [3:0]    req_be_i;
    logic [DW-1:0] req_wdata_i;
    logic          ram_select_i;
    logic          io_select_i;
    logic          ram_req_o;
    logic          io_req_o;
    logic [29:0]   tgt_addr_o;
    logic          tgt_we_o;
    logic [3:0]    tgt_be_o;
    logic [DW-1:0] tgt_wdata_o;
    logic          ram_ack_i;
    logic          io_ack_i;
    logic [DW-1:0] ram_rdata_i;
    logic [DW-1:0] io_rdata_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;

    bus_response_router #(
        .TIMEOUT_CYCLES (TO),
        .DATA_W         (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_be_i     (req_be_i),
        .req_wdata_i  (req_wdata_i),
        .ram_select_i (ram_select_i),
        .io_select_i  (io_select_i),
        .ram_req_o    (ram_req_o),
        .io_req_o     (io_req_o),
        .tgt_addr_o   (tgt_addr_o),
        .tgt_we_o     (tgt_we_o),
        .tgt_be_o     (tgt_be_o),
        .tgt_wdata_o  (tgt_wdata_o),
        .ram_ack_i    (ram_ack_i),
        .io_ack_i     (io_ack_i),
        .ram_rdata_i  (ram_rdata_i),
        .io_rdata_i   (io_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ram_strobes = 0;
    int   io_strobes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every rsp_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ram_req_o) ram_strobes++;
        if (io_req_o) io_strobes++;
        if (rsp_valid_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b at cycle %0d, required no response",
                         rsp_rdata_o, rsp_err_o, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_rdata_o !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata_o, mon_e.rdata);
                end
                checks++;
                if (rsp_err_o !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %b, required %b", rsp_err_o, mon_e.err);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL rsp_cycle: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
                $display("rsp: rdata=%h err=%b cycle=%0d", rsp_rdata_o, rsp_err_o, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [29:0] addr, input logic we, input logic [3:0] be,
                             input logic [DW-1:0] wdata, input logic rsel, input logic isel);
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_we_i     = we;
        req_be_i     = be;
        req_wdata_i  = wdata;
        ram_select_i = rsel;
        io_select_i  = isel;
    endtask

    task automatic idle_req();
        req_valid_i  = 1'b0;
        ram_select_i = 1'b0;
        io_select_i  = 1'b0;
    endtask

    // Bounded wait for all scoreboard entries to be consumed.
    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles, required 0",
                     sb_q.size(), bound);
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_req();
        req_addr_i = '0; req_we_i = 0; req_be_i = '0; req_wdata_i = '0;
        ram_ack_i = 0; io_ack_i = 0; ram_rdata_i = '0; io_rdata_i = '0;
        #1;
        checks++;
        if ({ram_req_o, io_req_o, tgt_we_o, tgt_be_o, rsp_valid_o, rsp_err_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0",
                     {ram_req_o, io_req_o, tgt_we_o, tgt_be_o, rsp_valid_o, rsp_err_o});
        end
        checks++;
        if (tgt_addr_o !== 30'h0 || tgt_wdata_o !== '0 || rsp_rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required all 0",
                     tgt_addr_o, tgt_wdata_o, rsp_rdata_o);
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", req_ready_o);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_ram_read();
        int a, br, bi;
        br = ram_strobes; bi = io_strobes;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL ram_read_ready: got %b, required 1", req_ready_o);
        end
        a = cyc;
        drive_req(30'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
        sb_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, cyc: a + 5});
        tick();
        idle_req();
        checks++;
        if (ram_req_o !== 1'b1 || io_req_o !== 1'b0) begin
            errors++;
            $display("FAIL ram_read_strobe: got ram=%b io=%b, required ram=1 io=0", ram_req_o, io_req_o);
        end
        checks++;
        if (tgt_addr_o !== 30'h0000_0010 || tgt_we_o !== 1'b0) begin
            errors++;
            $display("FAIL ram_read_tgt: got addr=%h we=%b, required addr=00000010 we=0", tgt_addr_o, tgt_we_o);
        end
        repeat (3) tick();
        ram_ack_i = 1'b1; ram_rdata_i = 32'hDEADBEEF;
        tick();
        ram_ack_i = 1'b0; ram_rdata_i = 32'h5A5A_5A5A;
        tick();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL ram_read_ready_after: got %b, required 1", req_ready_o);
        end
        wait_drain(5);
        checks++;
        if (ram_strobes - br != 1 || io_strobes - bi != 0) begin
            errors++;
            $display("FAIL ram_read_pulses: got ram=%0d io=%0d, required ram=1 io=0",
                     ram_strobes - br, io_strobes - bi);
        end
        $display("ram_read: accepted cycle %0d", a);
    endtask

    task automatic test_io_write();
        int a, br, bi;
        br = ram_strobes; bi = io_strobes;
        a = cyc;
        drive_req(30'h3C00_0001, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 1'b1);
        sb_q.push_back('{rdata: 32'h0, err: 1'b0, cyc: a + 2});
        tick();
        idle_req();
        checks++;
        if (io_req_o !== 1'b1 || ram_req_o !== 1'b0) begin
            errors++;
            $display("FAIL io_write_strobe: got ram=%b io=%b, required ram=0 io=1", ram_req_o, io_req_o);
        end
        checks++;
        if (tgt_addr_o !== 30'h3C00_0001 || tgt_we_o !== 1'b1 || tgt_be_o !== 4'hF ||
            tgt_wdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL io_write_tgt: got addr=%h we=%b be=%h wdata=%h, required 3c000001 1 f 12345678",
                     tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o);
        end
        io_ack_i = 1'b1; io_rdata_i = 32'hBAD0_BAD0;
        tick();
        io_ack_i = 1'b0;
        tick();
        wait_drain(5);
        checks++;
        if (ram_strobes - br != 0 || io_strobes - bi != 1) begin
            errors++;
            $display("FAIL io_write_pulses: got ram=%0d io=%0d, required ram=0 io=1",
                     ram_strobes - br, io_strobes - bi);
        end
        $display("io_write: accepted cycle %0d", a);
    endtask

    task automatic test_unmapped();
        int a, br, bi;
        br = ram_strobes; bi = io_strobes;
        a = cyc;
        drive_req(30'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: a + 1});
        tick();
        idle_req();
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++; $display("FAIL unmapped_busy: got ready=%b, required 0", req_ready_o);
        end
        tick();
        wait_drain(5);
        checks++;
        if (ram_strobes - br != 0 || io_strobes - bi != 0) begin
            errors++;
            $display("FAIL unmapped_pulses: got ram=%0d io=%0d, required 0 0",
                     ram_strobes - br, io_strobes - bi);
        end
        $display("unmapped: accepted cycle %0d", a);
    endtask

    task automatic test_timeout();
        int a;
        a = cyc;
        drive_req(30'h0000_0020, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
        sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: a + 6});
        tick();
        idle_req();
        ram_rdata_i = 32'h7777_7777;
        repeat (4) tick();
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++; $display("FAIL timeout_busy: got ready=%b at cycle %0d, required 0", req_ready_o, cyc);
        end
        repeat (2) tick();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL timeout_ready: got %b, required 1", req_ready_o);
        end
        // Stray late ack after the timeout must be dropped.
        ram_ack_i = 1'b1;
        tick();
        ram_ack_i = 1'b0;
        repeat (3) tick();
        wait_drain(5);
        $display("timeout: accepted cycle %0d", a);
    endtask

    task automatic test_wrong_target();
        int a;
        a = cyc;
        drive_req(30'h0000_0044, 1'b0, 4'h3, 32'h0, 1'b1, 1'b0);
        sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, cyc: a + 5});
        tick();
        idle_req();
        tick();
        io_ack_i = 1'b1; io_rdata_i = 32'h1111_1111;
        tick();
        io_ack_i = 1'b0;
        tick();
        ram_ack_i = 1'b1; ram_rdata_i = 32'hCAFE_F00D;
        tick();
        ram_ack_i = 1'b0;
        tick();
        wait_drain(5);
        $display("wrong_target: accepted cycle %0d", a);
    endtask

    task automatic test_back_to_back();
        logic [29:0]   t_addr  [4];
        logic          t_we    [4];
        logic          t_ram   [4];
        logic          t_io    [4];
        logic [DW-1:0] t_rdata [4];
        int a;
        t_addr = '{30'h0000_0100, 30'h3C00_0002, 30'h1000_0004, 30'h0000_0200};
        t_we   = '{1'b0, 1'b0, 1'b0, 1'b1};
        t_ram  = '{1'b1, 1'b0, 1'b0, 1'b1};
        t_io   = '{1'b0, 1'b1, 1'b0, 1'b1};
        t_rdata = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h8765_4321};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready_o !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, req_ready_o);
            end
            a = cyc;
            drive_req(t_addr[i], t_we[i], 4'hF, 32'h0000_0100 + i, t_ram[i], t_io[i]);
            if (t_ram[i] || t_io[i]) begin
                sb_q.push_back('{rdata: t_we[i] ? 32'h0 : t_rdata[i], err: 1'b0, cyc: a + 2});
            end else begin
                sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: a + 1});
            end
            tick();
            idle_req();
            if (t_ram[i] || t_io[i]) begin
                // Ack on the priority target only; a wrong route would time out.
                if (t_ram[i]) begin
                    ram_ack_i = 1'b1; ram_rdata_i = t_rdata[i];
                end else begin
                    io_ack_i = 1'b1; io_rdata_i = t_rdata[i];
                end
                tick();
                ram_ack_i = 1'b0; io_ack_i = 1'b0;
            end
            checks++;
            if (req_ready_o !== 1'b0) begin
                errors++; $display("FAIL b2b_resp_busy[%0d]: got ready=%b, required 0", i, req_ready_o);
            end
            tick();
            $display("b2b[%0d]: addr=%h accepted cycle %0d", i, t_addr[i], a);
        end
        wait_drain(5);
    endtask

    task automatic test_reset_mid();
        int br;
        br = ram_strobes;
        drive_req(30'h3FFF_FFFF, 1'b1, 4'h5, 32'hAAAA_5555, 1'b1, 1'b0);
        tick();
        idle_req();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_req_o, io_req_o, tgt_we_o, tgt_be_o, rsp_valid_o, rsp_err_o} !== 9'b0 ||
            tgt_addr_o !== 30'h0 || tgt_wdata_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got addr=%h we=%b be=%h wdata=%h strobes=%b%b, required all 0",
                     tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o, ram_req_o, io_req_o);
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready: got %b, required 1", req_ready_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready_after: got %b, required 1", req_ready_o);
        end
        ram_ack_i = 1'b1;
        tick();
        ram_ack_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (ram_strobes - br != 1) begin
            errors++; $display("FAIL mid_reset_pulses: got %0d, required 1", ram_strobes - br);
        end
        wait_drain(5);
        $display("reset_mid: done at cycle %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_io_write();
        test_unmapped();
        test_timeout();
        test_wrong_target();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_response_router.md
# bus_response_router

Sequential request/response router on the CPU data bus, paired with the combinational address decoder. It takes the decoder's `ram_select`/`io_select` outputs together with a CPU request and forwards the request to the chosen target as a one-cycle strobe. It then waits for that target's acknowledge, or a timeout, and returns registered read data or an error response to the CPU. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait cycles before a bus error; legal range 1..65535
- `DATA_W`, default 32: data width

Ports (reset is asynchronous, active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `req_valid_i`  in  1  CPU request valid
- `req_ready_o`  out  1  router can accept a request
- `req_addr_i`  in  30  word address, forwarded unchanged
- `req_we_i`  in  1  1 = write
- `req_be_i`  in  4  byte enables
- `req_wdata_i`  in  DATA_W  write data
- `ram_select_i`  in  1  from address decoder
- `io_select_i`  in  1  from address decoder
- `ram_req_o` / `io_req_o`  out  1  one-cycle target strobe
- `tgt_addr_o`  out  30  latched address
- `tgt_we_o`  out  1  latched write enable
- `tgt_be_o`  out  4  latched byte enables
- `tgt_wdata_o`  out  DATA_W  latched write data
- `ram_ack_i` / `io_ack_i`  in  1  target completion
- `ram_rdata_i` / `io_rdata_i`  in  DATA_W  target read data, valid with ack
- `rsp_valid_o`  out  1  one-cycle response pulse
- `rsp_rdata_o`  out  DATA_W  read data; 0 on writes and errors
- `rsp_err_o`  out  1  unmapped address or timeout

## Operation
States:
- IDLE
- ISSUE
- WAIT
- RESP

Transitions and actions:
- `req_ready_o` = (state == IDLE).
- IDLE: on `req_valid_i`, latch addr/we/be/wdata and target into the `tgt_*` registers. Target is RAM if `ram_select_i`, else IO if `io_select_i`, else NONE; RAM wins if both are set.
  - NONE: go to RESP with err=1.
  - RAM or IO: go to ISSUE.
- ISSUE: assert exactly one of `ram_req_o`/`io_req_o` for one cycle, clear the timeout counter, go to WAIT.
- WAIT: counter increments each cycle.
  - Ack from the latched target: capture rdata (0 if write), err=0, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES - 1` with no ack: err=1, rdata=0, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP: `rsp_valid_o`=1 for one cycle with the latched rdata/err, go to IDLE.

Ignored inputs:
- Acks from the non-selected target are ignored in all states.
- Any ack outside WAIT is ignored; a late ack after a timeout is dropped.

`tgt_*` outputs hold their latched values from acceptance until the next acceptance.

## Timing
- Reset values: all state is IDLE, and every output is 0 except `req_ready_o`=1.
- Accept at edge N: strobe high in cycle N+1.
- Earliest ack is cycle N+1, sampled with the strobe. That is legal and counts as the first WAIT sample (ISSUE also checks ack).
- Ack at edge M: `rsp_valid_o` high in cycle M+1. Best-case request-to-response is 2 cycles.
- Unmapped: `rsp_valid_o` high in cycle N+1 with err=1.
- Timeout: response in cycle N+1+TIMEOUT_CYCLES+1.
- Back-to-back: `req_ready_o` returns high in the cycle after `rsp_valid_o`.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Reset asserted mid-transaction: return to IDLE immediately, drop strobes, emit no response.

## Structure
- Shared `bus_pkg`:
  - `target_e` {TGT_NONE, TGT_RAM, TGT_IO}
  - `state_e`
  - `DATA_W` and `ADDR_W`=30 constants
- One sub-module, `bus_timeout_counter`: clear, enable, expired, parameterised limit.
- The address decoder stays external; the router only consumes its selects.

## Test plan
- RAM read: addr 'h0000_0010, ram ack 3 cycles after strobe with rdata 'hDEADBEEF -> `rsp_valid_o` once, rdata 'hDEADBEEF, err 0, total 5 cycles.
- IO write: addr 'h3C00_0001 (io_select=1), be 'hF, wdata 'h12345678, immediate ack -> `io_req_o` one pulse, `ram_req_o` never set, rsp rdata 0, err 0.
- Unmapped: addr 'h1000_0000, both selects 0 -> no strobe, `rsp_valid_o` the next cycle with err=1.
- Timeout: TIMEOUT_CYCLES=4, RAM never acks -> err=1 response exactly 6 cycles after acceptance. A later stray ack produces no response.
- Wrong-target ack: RAM selected, io_ack pulses, then ram_ack 2 cycles later -> only the ram_ack completes, with ram_rdata.
- Reset mid-WAIT: drop `rst_n` during WAIT -> all outputs reset asynchronously, `req_ready_o`=1 after release, no response emitted.
